// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master: 11-bit command frame out, optional 8-bit read-back.
// Define SPI_MASTER_ABORT_EN to add the abort input and aborted pulse output.
module spi_master_ctrl #(
  parameter int CLK_DIV   = 2,
  parameter int TURN_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] cmd,
`ifdef SPI_MASTER_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SCLK,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [4:0]    TURN_LAST = 5'(TURN_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SHIFT_OUT, S_TURN, S_SHIFT_IN, S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [10:0] sh_q, sh_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_op_q, rd_op_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ss_n_q, ss_n_d;
  logic        sclk_q, sclk_d;
  logic        go_finish;
  logic        div_wrap;
  logic        last_period;
`ifdef SPI_MASTER_ABORT_EN
  logic        aborted_q, aborted_d;
`endif

  assign div_wrap    = (div_q == DIV_LAST);
  assign last_period = (state_q == S_SHIFT_OUT) ? (bit_q == 5'd10) :
                       (state_q == S_TURN)      ? (bit_q == TURN_LAST) :
                                                  (bit_q == 5'd7);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_op_d    = rd_op_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    ss_n_d     = ss_n_q;
    sclk_d     = sclk_q;
    go_finish  = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    aborted_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SELECT;
          sh_d    = {cmd[9], cmd};
          rd_op_d = &cmd[9:8];
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_SELECT: begin
        div_d = div_wrap ? '0 : div_q + DW'(1);
        if (div_wrap) begin
          state_d = S_SHIFT_OUT;
          sclk_d  = 1'b1;
        end
      end
      S_SHIFT_OUT, S_TURN, S_SHIFT_IN: begin
        div_d = div_wrap ? '0 : div_q + DW'(1);
        // MISO is captured at the end of the first high cycle, while the slave holds it stable.
        if (state_q == S_SHIFT_IN && sclk_q && div_q == '0)
          rx_d = {rx_q[6:0], MISO};
        if (div_wrap) begin
          sclk_d = ~sclk_q;
          if (sclk_q && state_q == S_SHIFT_OUT)
            sh_d = {sh_q[9:0], 1'b0};
          if (!sclk_q) begin
            bit_d = bit_q + 5'd1;
            if (last_period) begin
              bit_d = 5'd0;
              if (state_q == S_SHIFT_OUT && rd_op_q)
                state_d = (TURN_BITS == 0) ? S_SHIFT_IN : S_TURN;
              else if (state_q == S_TURN)
                state_d = S_SHIFT_IN;
              else
                go_finish = 1'b1;
            end
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (go_finish) begin
      state_d = S_FINISH;
      sclk_d  = 1'b0;
      ss_n_d  = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      sh_d    = '0;
      div_d   = '0;
      if (state_q == S_SHIFT_IN) begin
        rd_data_d  = rx_q;
        rd_valid_d = 1'b1;
      end
    end
    if (state_q == S_FINISH) busy_d = 1'b0;

`ifdef SPI_MASTER_ABORT_EN
    if (abort && busy_q) begin
      state_d    = S_IDLE;
      sclk_d     = 1'b0;
      ss_n_d     = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      sh_d       = '0;
      div_d      = '0;
      bit_d      = 5'd0;
      aborted_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= 5'd0;
      sh_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_op_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
`ifdef SPI_MASTER_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_op_q    <= rd_op_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ss_n_q     <= ss_n_d;
      sclk_q     <= sclk_d;
`ifdef SPI_MASTER_ABORT_EN
      aborted_q  <= aborted_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign SCLK     = sclk_q;
  assign SS_n     = ss_n_q;
  assign MOSI     = sh_q[10];
`ifdef SPI_MASTER_ABORT_EN
  assign aborted  = aborted_q;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed bench for spi_master_ctrl with a byte-returning slave model.
module tb_spi_master_ctrl;
  localparam int CLK_DIV   = 2;
  localparam int TURN_BITS = 2;
  localparam int RD_FIRST  = 11 + TURN_BITS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] cmd = '0;
  logic       busy, done, rd_valid, SCLK, SS_n, MOSI;
  logic [7:0] rd_data;
  logic       MISO = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
  logic       abort = 1'b0;
  logic       aborted;
`endif

  spi_master_ctrl #(.CLK_DIV(CLK_DIV), .TURN_BITS(TURN_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd),
`ifdef SPI_MASTER_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  int ss_low, hi_run, frames, rises, falls, done_cnt, rv_cnt, both_cnt, abort_cnt;
  int min_gap, max_gap;
  bit seen_frame;
  logic [31:0] mosi_bits;
  logic [7:0]  rd_cap;
  logic [7:0]  slave_byte = 8'h00;
  logic        ss_prev = 1'b1;
  logic        sclk_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ss_low = 0; hi_run = 0; frames = 0; rises = 0; done_cnt = 0; rv_cnt = 0;
    both_cnt = 0; abort_cnt = 0; min_gap = 999; max_gap = 0; seen_frame = 0;
    mosi_bits = '0; rd_cap = '0;
  endtask

  task automatic start_frame(input logic [9:0] c);
    cmd = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic wait_rises(input int n, input int budget, input string tag);
    int k = 0;
    while (rises < n && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(rises >= n), 32'd1);
  endtask

  // Bus monitor plus slave: slave shifts slave_byte out MSB first, changing MISO after SCLK falls.
  always @(negedge clk) begin
    if (!SS_n) ss_low++;
    else hi_run++;
    if (!SS_n && ss_prev) begin
      frames++;
      if (seen_frame) begin
        if (hi_run < min_gap) min_gap = hi_run;
        if (hi_run > max_gap) max_gap = hi_run;
      end
      seen_frame = 1;
      hi_run = 0;
    end
    if (SCLK && !sclk_prev && !SS_n) begin
      rises++;
      mosi_bits = {mosi_bits[30:0], MOSI};
    end
    if (done) done_cnt++;
    if (rd_valid) rv_cnt++;
    if (done && rd_valid) begin
      both_cnt++;
      rd_cap = rd_data;
    end
`ifdef SPI_MASTER_ABORT_EN
    if (aborted) abort_cnt++;
`endif
    if (SS_n) begin
      falls = 0;
      MISO = 1'b0;
    end else if (!SCLK && sclk_prev) begin
      falls++;
      if (falls >= RD_FIRST && falls < RD_FIRST + 8) MISO = slave_byte[7 - (falls - RD_FIRST)];
      else MISO = 1'b0;
    end
    ss_prev = SS_n;
    sclk_prev = SCLK;
  end

  initial begin
    clear_mon();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_ss_n", 32'(SS_n), 32'd1);
    check_eq("rst_sclk", 32'(SCLK), 32'd0);
    check_eq("rst_mosi", 32'(MOSI), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'h00);

    // Write frame
    clear_mon();
    start_frame(10'b01_1010_0101);
    check_eq("wr_busy_after_accept", 32'(busy), 32'd1);
    wait_done(1, 200, "wr_done_seen");
    check_eq("wr_busy_at_done", 32'(busy), 32'd0);
    repeat (5) tick();
    check_eq("wr_mosi_bits", mosi_bits, 32'h1A5);
    check_eq("wr_rises", 32'(rises), 32'd11);
    check_eq("wr_ss_low", 32'(ss_low), 32'd46);
    check_eq("wr_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("wr_rv_cnt", 32'(rv_cnt), 32'd0);

    // Read-data frame
    clear_mon();
    slave_byte = 8'hA5;
    start_frame(10'b11_0000_0000);
    wait_done(1, 300, "rd_done_seen");
    repeat (5) tick();
    check_eq("rd_ss_low", 32'(ss_low), 32'd86);
    check_eq("rd_rises", 32'(rises), 32'd21);
    check_eq("rd_mosi_bits", mosi_bits, 32'h1C0000);
    check_eq("rd_both_cnt", 32'(both_cnt), 32'd1);
    check_eq("rd_rv_cnt", 32'(rv_cnt), 32'd1);
    check_eq("rd_cap", 32'(rd_cap), 32'hA5);
    check_eq("rd_data_hold", 32'(rd_data), 32'hA5);

    // start during an active frame is ignored
    clear_mon();
    start_frame(10'h0C3);
    repeat (3) tick();
    cmd = 10'h3FF; start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();
    start = 1'b1; tick(); start = 1'b0; cmd = 10'h0C3;
    wait_done(1, 200, "ign_done_seen");
    repeat (10) tick();
    check_eq("ign_mosi_bits", mosi_bits, 32'h0C3);
    check_eq("ign_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("ign_frames", 32'(frames), 32'd1);

    // Reset in the 6th SCLK period
    clear_mon();
    start_frame(10'h155);
    wait_rises(6, 200, "rst_mid_reached");
    rst = 1'b1;
    tick();
    check_eq("rst_mid_ss_n", 32'(SS_n), 32'd1);
    check_eq("rst_mid_sclk", 32'(SCLK), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_mosi", 32'(MOSI), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check_eq("rst_mid_no_done", 32'(done_cnt), 32'd0);
    clear_mon();
    start_frame(10'h155);
    wait_done(1, 200, "post_rst_done_seen");
    check_eq("post_rst_mosi_bits", mosi_bits, 32'h155);
    check_eq("post_rst_ss_low", 32'(ss_low), 32'd46);

    // Back-to-back frames with start held high
    clear_mon();
    cmd = 10'h0F0;
    start = 1'b1;
    wait_done(3, 400, "b2b_done_seen");
    start = 1'b0;
    repeat (6) tick();
    check_eq("b2b_frames", 32'(frames), 32'd3);
    check_eq("b2b_done_cnt", 32'(done_cnt), 32'd3);
    check_eq("b2b_min_gap", 32'(min_gap), 32'd2);
    check_eq("b2b_max_gap", 32'(max_gap), 32'd2);
    check_eq("b2b_ss_low", 32'(ss_low), 32'd138);

`ifdef SPI_MASTER_ABORT_EN
    clear_mon();
    slave_byte = 8'h3C;
    start_frame(10'b11_0000_0000);
    wait_done(1, 300, "ab_pre_done_seen");
    tick();
    check_eq("ab_pre_rd_data", 32'(rd_data), 32'h3C);
    clear_mon();
    slave_byte = 8'hA5;
    start_frame(10'b11_0000_0000);
    wait_rises(15, 300, "ab_shift_in_reached");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_aborted", 32'(aborted), 32'd1);
    check_eq("ab_ss_n", 32'(SS_n), 32'd1);
    check_eq("ab_sclk", 32'(SCLK), 32'd0);
    check_eq("ab_mosi", 32'(MOSI), 32'd0);
    check_eq("ab_busy", 32'(busy), 32'd0);
    repeat (8) tick();
    check_eq("ab_abort_cnt", 32'(abort_cnt), 32'd1);
    check_eq("ab_done_cnt", 32'(done_cnt), 32'd0);
    check_eq("ab_rv_cnt", 32'(rv_cnt), 32'd0);
    check_eq("ab_rd_data", 32'(rd_data), 32'h3C);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master that drives the ~SS_n/SCLK/MOSI/MISO link to the team's SPI slave/RAM bridge.
- The host issues one 10-bit command per transaction: opcode[9:8] followed by address or data[7:0].
- For read-data commands (opcode 2'b11), the block also shifts back 8 bits from MISO and presents them to the host.
- Runs entirely in the system clock domain; SCLK is derived by an internal divider.

Parameters:
- CLK_DIV, 2, SCLK half-period in clk cycles; legal range >=1.
- TURN_BITS, 2, dummy SCLK periods between the last command bit and the first read-data bit; legal range >=0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a transaction; accepted only when busy=0.
- cmd  in  10  command frame, latched on acceptance; bits [9:8] are the opcode.
- busy  out  1  high from the cycle after acceptance until the done cycle.
- done  out  1  one-cycle pulse at the end of every transaction.
- rd_data  out  8  data returned by a read-data transaction; holds until the next read.
- rd_valid  out  1  one-cycle pulse, coincident with done, on read-data transactions only.
- SCLK  out  1  serial clock, idles low.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data out, MSB first.
- MISO  in  1  serial data in, MSB first.

Behaviour:
- Reset, and the idle state: SS_n=1, SCLK=0, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, all counters 0.
- Reset asserted mid-transaction: the outputs above take these values at the next clk edge. No done pulse is generated and the frame is abandoned.
- Transmitted frame: 11 bits = {cmd[9], cmd[9:0]}. The leading bit is the slave's read/write selector; the next 10 bits are the payload, MSB first.
- FSM states and transitions:
  - IDLE -> SELECT when start is high. cmd is latched; busy goes high next cycle.
  - SELECT: SS_n=0, MOSI=first bit, SCLK=0. Held for CLK_DIV cycles, then -> SHIFT_OUT.
  - SHIFT_OUT: 11 SCLK periods, each CLK_DIV cycles high then CLK_DIV cycles low. MOSI advances to the next bit on the cycle SCLK falls. After the 11th period: if latched opcode==2'b11 -> TURN, else -> FINISH.
  - TURN: TURN_BITS SCLK periods with MOSI=0, then -> SHIFT_IN. If TURN_BITS=0, go directly to SHIFT_IN.
  - SHIFT_IN: 8 SCLK periods with MOSI=0. MISO is sampled into a shift register on the clk cycle SCLK rises, MSB first. Then -> FINISH.
  - FINISH: single cycle. SS_n=1, SCLK=0, done=1, busy=0. On reads, rd_data is loaded and rd_valid=1. Next state is IDLE.
- start while busy=1: ignored; cmd is not re-latched.
- start in the FINISH cycle: ignored. The earliest accepted start is in the cycle after done.
- Minimum SS_n high time between frames: 2 clk cycles.
- Frame length (SS_n low), in clk cycles:
  - write/read-address (opcode != 2'b11): CLK_DIV + 22*CLK_DIV.
  - read-data (opcode == 2'b11): CLK_DIV + 2*CLK_DIV*(19+TURN_BITS).
- Width rules: bit counter is 5 bits; divider counter is $clog2(CLK_DIV)+1 bits, wrapping to 0 at CLK_DIV-1. No other arithmetic.

Optional Feature:
- Macro: SPI_MASTER_ABORT_EN.
- With the macro defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort high while busy=1 forces the FINISH-equivalent outputs at the next edge: SS_n=1, SCLK=0, MOSI=0, busy=0.
  - aborted pulses for one cycle; done and rd_valid stay low; rd_data is unchanged.
  - abort while idle has no effect.
- Without the macro: neither port exists, and every accepted frame runs to completion.

Test Plan:
- Write command, CLK_DIV=2, cmd=10'b01_1010_0101 -> MOSI bit sequence 0,0,1,1,0,1,0,0,1,0,1 across 11 SCLK rising edges. SS_n low for exactly 46 cycles; one done pulse; rd_valid stays 0.
- Read-data, CLK_DIV=2, TURN_BITS=2, cmd=10'b11_0000_0000, slave model drives 8'hA5 MSB first during SHIFT_IN -> SS_n low 86 cycles; rd_data=8'hA5 with rd_valid and done high on the same cycle.
- start pulsed at cycles 5 and 20 of an active frame with a different cmd -> ignored. MOSI still carries the first cmd; exactly one done pulse.
- rst asserted during the 6th SCLK period -> SS_n=1, SCLK=0, busy=0 at the next edge; no done pulse. A new write frame then completes normally.
- Back-to-back: start held high continuously with cmd=10'h0F0 -> frames separated by 2 cycles of SS_n high; done pulses exactly once per frame.
- SPI_MASTER_ABORT_EN: abort during SHIFT_IN of a read-data frame with rd_data previously 8'h3C -> aborted pulses once, done=0, rd_valid=0, rd_data stays 8'h3C.
